// File: rtl/ram_address_scanner.sv
// ram_address_scanner
// Reads a 32-word synchronous RAM one address at a time for the board display.
// The returned byte is latched and split into display nibbles. The address
// advances on a timed tick (Run=1) or on a Step rising edge (Run=0), or is
// loaded directly from JumpAddr.
//
// Ports:
//   Clock    - system clock, rising edge
//   Resetn   - synchronous active-low reset
//   Run      - 1: auto-advance on tick, 0: manual stepping
//   Step     - step request, rising edge used
//   Jump     - level, loads JumpAddr in SHOW
//   JumpAddr - jump target address
//   RdData   - RAM read data, valid the cycle after RdEn
//   RdEn     - RAM read enable (high in FETCH only)
//   Addr     - current RAM / display address
//   AddrHi   - Addr MSB digit
//   AddrLo   - Addr[3:0]
//   DataHi   - latched data high nibble
//   DataLo   - latched data low nibble
//   Valid    - data fields belong to the current Addr
module ram_address_scanner #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic              Step,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] JumpAddr,
  input  logic [DATA_W-1:0] RdData,
  output logic              RdEn,
  output logic [ADDR_W-1:0] Addr,
  output logic              AddrHi,
  output logic [3:0]        AddrLo,
  output logic [3:0]        DataHi,
  output logic [3:0]        DataLo,
  output logic              Valid
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_rd_en;
  logic              r_step_d;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_step_rise;
  logic              w_tick;
  logic              w_advance;
  logic [ADDR_W-1:0] w_next_addr;

  // Advance decision for SHOW; Jump outranks tick and step.
  assign w_step_rise = Step & ~r_step_d;
  assign w_tick      = Run & (r_cnt == TICK_LAST);
  assign w_advance   = Jump | w_tick | (~Run & w_step_rise);
  assign w_next_addr = Jump ? JumpAddr : r_addr + ADDR_W'(1);

  // Sequencer: state, address, data latch, tick counter and step history.
  // RdEn is registered alongside every transition into FETCH.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_step_d <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_step_d <= Step;
      r_rd_en  <= 1'b0;
      if (!Run) begin
        r_cnt <= '0;
      end
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_rd_en <= 1'b1;
        end
        S_FETCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_data  <= RdData;
          r_valid <= 1'b1;
          r_state <= S_SHOW;
        end
        S_SHOW: begin
          if (w_advance) begin
            r_addr  <= w_next_addr;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_FETCH;
            r_rd_en <= 1'b1;
          end else if (Run) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Display fields are plain slices of the registers.
  assign RdEn   = r_rd_en;
  assign Addr   = r_addr;
  assign AddrHi = r_addr[ADDR_W-1];
  assign AddrLo = r_addr[3:0];
  assign DataHi = r_data[DATA_W-1 -: 4];
  assign DataLo = r_data[3:0];
  assign Valid  = r_valid;

endmodule

// File: doc/ram_address_scanner.md
Name: ram_address_scanner

Overview:
- Sequences reads of a 32-word synchronous RAM for the board display path.
- Holds the current 5-bit address and issues one read per address.
- Latches the returned byte and splits address and data into display fields: the 1-bit address MSB digit, the low address nibble, and two data nibbles.
- Advances the address automatically on a timed tick (Run=1), manually on a Step pulse (Run=0), or loads it directly from JumpAddr.

Parameters:
ADDR_W, 5, RAM address width; AddrHi is bit ADDR_W-1 and AddrLo is bits 3:0.
DATA_W, 8, RAM data width; split into DataHi and DataLo nibbles.
TICK_DIV, 50000000, number of SHOW cycles per auto-advance (1 s at 50 MHz); must be at least 1.

Ports:
Clock  input  1  system clock; all state changes on its rising edge.
Resetn  input  1  synchronous active-low reset, sampled on the rising edge of Clock.
Run  input  1  1 = auto-advance on tick; 0 = manual stepping.
Step  input  1  active-high step request (top level inverts KEY); the rising edge is used.
Jump  input  1  active-high level; loads JumpAddr.
JumpAddr  input  ADDR_W  target address for Jump.
RdData  input  DATA_W  RAM read data, valid in the cycle after RdEn.
RdEn  output  1  RAM read enable.
Addr  output  ADDR_W  RAM address and current display address.
AddrHi  output  1  Addr[4], for the one-digit 0/1 display.
AddrLo  output  4  Addr[3:0].
DataHi  output  4  latched data[7:4].
DataLo  output  4  latched data[3:0].
Valid  output  1  high when DataHi/DataLo hold data for the current Addr.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are Clock and Resetn.
- Reset (Resetn=0 at an edge):
  - state=IDLE, Addr=0, data register=0, Valid=0.
  - Tick counter=0, Step_d (step history register)=0.
  - RdEn=0 because it is a Moore output of IDLE.
  - Reset applies in any state, including mid-read; a read in progress is abandoned and not latched.
- States (Moore outputs; RdEn=1 only in FETCH):
  - IDLE: next state is FETCH, unconditionally.
  - FETCH: RdEn=1 with the current Addr. Next state is WAIT.
  - WAIT: RdData is valid. At the edge, data register<=RdData, Valid<=1, state<=SHOW.
  - SHOW: evaluates the advance conditions below in priority order. If none holds, it stays in SHOW.
- Advance conditions in SHOW:
  1. Jump=1: Addr<=JumpAddr.
  2. Run=1 and counter==TICK_DIV-1: Addr<=Addr+1.
  3. Run=0 and Step rising edge (Step & ~Step_d): Addr<=Addr+1.
  - On any advance: Valid<=0, counter<=0, state<=FETCH.
- Address arithmetic: modulo 2^ADDR_W; 31+1 wraps to 0. No carry out.
- Tick counter:
  - Increments only in SHOW while Run=1.
  - Cleared on advance, whenever Run=0, and on reset.
  - SHOW therefore lasts exactly TICK_DIV cycles in auto mode, giving an address period of TICK_DIV+2 cycles.
- Step edge detection:
  - Step_d<=Step every cycle in all states except reset.
  - Rising edges that occur outside SHOW, or while Run=1, are discarded (not queued).
- Jump behaviour:
  - Jump is level-sensitive. Held high, it reloads JumpAddr each time SHOW is reached, one reload every 3 cycles.
  - Jump has priority over a simultaneous tick or step.
  - If JumpAddr equals Addr, a re-read still occurs.
- Latency: for an advance decided at the edge ending SHOW cycle t:
  - Addr is new in cycle t+1, with RdEn=1.
  - WAIT is cycle t+2.
  - Valid=1 with new data from cycle t+3.
- Display fields: AddrHi, AddrLo, DataHi and DataLo are direct wire slices of the registers. Data fields keep their old value while Valid=0.
- Run toggling mid-read has no effect until SHOW.

Test Plan:
1. Reset held 2 cycles, then release; RAM[0]=0xA5 -> RdEn=1 in cycle 1 (FETCH) with Addr=0. Cycle 3: Valid=1, DataHi=A, DataLo=5, AddrHi=0, AddrLo=0.
2. Run=0, three separate Step pulses, each 1 cycle high, spaced ≥4 cycles -> Addr=3, AddrLo=3. Step held high 20 cycles -> exactly one advance.
3. Jump=1 with JumpAddr=31 for one SHOW cycle, then one Step -> Addr=31 (AddrHi=1, AddrLo=F), then Addr=0 (wrap), with RAM[0] data shown again.
4. TICK_DIV=4, Run=1 -> Addr increments every 6 cycles: 0,1,2,… through 31 back to 0. Valid is low for exactly 2 cycles per period (FETCH, WAIT).
5. In SHOW with Run=0, Jump=1 (JumpAddr=10) and a Step edge in the same cycle -> Addr=10, not Addr+1. Addr+1 never appears.
6. Resetn=0 during WAIT, with RdData=0xFF present -> next cycle Addr=0, Valid=0, DataHi/DataLo=0, RdEn=0. 0xFF is never latched.
